// File: rtl/state_sequencer_pkg.sv
// Shared encodings for the instruction sequencer and the control unit:
// state codes, opcode codes and the state-to-status-flag mapping.
package state_sequencer_pkg;

    localparam int STATE_W = 6;

    localparam logic [5:0] ST_IDLE   = 6'd0;
    localparam logic [5:0] ST_FETCH1 = 6'd1;
    localparam logic [5:0] ST_FETCH2 = 6'd2;
    localparam logic [5:0] ST_FETCH3 = 6'd3;
    localparam logic [5:0] ST_CLAC   = 6'd4;
    localparam logic [5:0] ST_LDAC1  = 6'd5;
    localparam logic [5:0] ST_LDAC2  = 6'd6;
    localparam logic [5:0] ST_LDAC3  = 6'd7;
    localparam logic [5:0] ST_STAC1  = 6'd8;
    localparam logic [5:0] ST_STAC2  = 6'd9;
    localparam logic [5:0] ST_STAC3  = 6'd10;
    localparam logic [5:0] ST_MVACR  = 6'd11;
    localparam logic [5:0] ST_MVRAC  = 6'd12;
    localparam logic [5:0] ST_ADD    = 6'd13;
    localparam logic [5:0] ST_MUL    = 6'd14;
    localparam logic [5:0] ST_HALT   = 6'd15;
    localparam logic [5:0] ST_DECODE = 6'd16;
    localparam logic [5:0] ST_ERROR  = 6'd17;

    localparam logic [3:0] OP_CLAC  = 4'd0;
    localparam logic [3:0] OP_LDAC  = 4'd1;
    localparam logic [3:0] OP_STAC  = 4'd2;
    localparam logic [3:0] OP_MVACR = 4'd3;
    localparam logic [3:0] OP_MVRAC = 4'd4;
    localparam logic [3:0] OP_ADD   = 4'd5;
    localparam logic [3:0] OP_MUL   = 4'd6;
    localparam logic [3:0] OP_END   = 4'd15;

    typedef struct packed {
        logic running;
        logic paused;
        logic halted;
        logic illegal;
    } seq_flags_t;

    // Status flags for a state; 'park' distinguishes a step pause from plain IDLE.
    function automatic seq_flags_t state_flags(input logic [5:0] st, input logic park);
        seq_flags_t f;
        f.halted  = (st == ST_HALT);
        f.illegal = (st == ST_ERROR);
        f.paused  = (st == ST_IDLE) && park;
        f.running = !((st == ST_IDLE) || (st == ST_HALT) || (st == ST_ERROR));
        return f;
    endfunction

    // First execute state for a decoded opcode; unknown codes trap to ERROR.
    function automatic logic [5:0] exec_entry(input logic [3:0] op);
        logic [5:0] st;
        case (op)
            OP_CLAC:  st = ST_CLAC;
            OP_LDAC:  st = ST_LDAC1;
            OP_STAC:  st = ST_STAC1;
            OP_MVACR: st = ST_MVACR;
            OP_MVRAC: st = ST_MVRAC;
            OP_ADD:   st = ST_ADD;
            OP_MUL:   st = ST_MUL;
            OP_END:   st = ST_HALT;
            default:  st = ST_ERROR;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/state_sequencer.sv
// Fetch/decode/execute sequencer with single-step support and a
// retired-instruction counter.
module state_sequencer
    import state_sequencer_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               step_en,
    input  logic               step_go,
    input  logic [3:0]         ir_opcode,
    output logic [5:0]         state,
    output logic               running,
    output logic               paused,
    output logic               halted,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    logic [5:0] state_nx;
    logic       park_nx;
    logic       dec_wait;
    logic       wait_nx;
    logic       retire;
    seq_flags_t flags_q;
    seq_flags_t flags_nx;

    assign running = flags_q.running;
    assign paused  = flags_q.paused;
    assign halted  = flags_q.halted;
    assign illegal = flags_q.illegal;

    // Next-state decode; start/step inputs only matter in the parked states.
    always_comb begin
        state_nx = state;
        park_nx  = flags_q.paused;
        wait_nx  = dec_wait;
        retire   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start || (flags_q.paused && step_go)) begin
                    state_nx = ST_FETCH1;
                    park_nx  = 1'b0;
                end
            end
            ST_FETCH1: state_nx = ST_FETCH2;
            ST_FETCH2: state_nx = ST_FETCH3;
            ST_FETCH3: begin
                state_nx = ST_DECODE;
                wait_nx  = 1'b0;
            end
            // Control word is registered: opcode is only valid on the second cycle.
            ST_DECODE: begin
                if (!dec_wait) begin
                    wait_nx = 1'b1;
                end else begin
                    wait_nx  = 1'b0;
                    state_nx = exec_entry(ir_opcode);
                end
            end
            ST_LDAC1: state_nx = ST_LDAC2;
            ST_LDAC2: state_nx = ST_LDAC3;
            ST_STAC1: state_nx = ST_STAC2;
            ST_STAC2: state_nx = ST_STAC3;
            ST_CLAC, ST_LDAC3, ST_STAC3, ST_MVACR, ST_MVRAC, ST_ADD, ST_MUL: begin
                retire = 1'b1;
                if (step_en) begin
                    state_nx = ST_IDLE;
                    park_nx  = 1'b1;
                end else begin
                    state_nx = ST_FETCH1;
                end
            end
            ST_HALT, ST_ERROR: begin
                if (start) state_nx = ST_FETCH1;
            end
            default: state_nx = ST_IDLE;
        endcase
        flags_nx = state_flags(state_nx, park_nx);
    end

    // State, decode wait bit, registered flags and retire counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            dec_wait    <= 1'b0;
            flags_q     <= '0;
            instr_count <= '0;
        end else begin
            state    <= state_nx;
            dec_wait <= wait_nx;
            flags_q  <= flags_nx;
            if (retire) instr_count <= instr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench: a queue-based instruction model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_state_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        step_en = 1'b0;
    logic        step_go = 1'b0;
    logic [3:0]  ir_opcode = 4'd0;

    logic [5:0]  state, state4;
    logic        running, paused, halted, illegal;
    logic        running4, paused4, halted4, illegal4;
    logic [15:0] instr_count;
    logic [3:0]  instr_count4;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // model
    int q[$];
    int m_state = 0;
    bit m_paused = 1'b0;
    int m_count = 0;

    state_sequencer #(.COUNT_W(16)) dut (
        .clock(clock), .reset(reset), .start(start), .step_en(step_en),
        .step_go(step_go), .ir_opcode(ir_opcode), .state(state),
        .running(running), .paused(paused), .halted(halted),
        .illegal(illegal), .instr_count(instr_count)
    );

    state_sequencer #(.COUNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .start(start), .step_en(step_en),
        .step_go(step_go), .ir_opcode(ir_opcode), .state(state4),
        .running(running4), .paused(paused4), .halted(halted4),
        .illegal(illegal4), .instr_count(instr_count4)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an instruction is a list of states; the opcode picks the
    // execute list once the fetch/decode list has drained.
    always @(posedge clock) begin
        if (reset) begin
            q.delete();
            m_state  = 0;
            m_paused = 1'b0;
            m_count  = 0;
        end else if (q.size() > 0) begin
            m_state = q.pop_front();
        end else if (m_state == 16) begin
            case (ir_opcode)
                4'd0:    q = '{4};
                4'd1:    q = '{5, 6, 7};
                4'd2:    q = '{8, 9, 10};
                4'd3:    q = '{11};
                4'd4:    q = '{12};
                4'd5:    q = '{13};
                4'd6:    q = '{14};
                4'd15:   q = '{15};
                default: q = '{17};
            endcase
            m_state = q.pop_front();
        end else if (m_state >= 4 && m_state <= 14) begin
            m_count++;
            if (step_en) begin
                m_state  = 0;
                m_paused = 1'b1;
            end else begin
                q = '{1, 2, 3, 16, 16};
                m_state = q.pop_front();
            end
        end else if (start || (m_paused && step_go)) begin
            m_paused = 1'b0;
            q = '{1, 2, 3, 16, 16};
            m_state = q.pop_front();
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (mon_en) begin
            chk("state", int'(state), m_state);
            chk("state4", int'(state4), m_state);
            chk("running", int'(running), int'(!(m_state == 0 || m_state == 15 || m_state == 17)));
            chk("paused", int'(paused), int'(m_paused));
            chk("halted", int'(halted), int'(m_state == 15));
            chk("illegal", int'(illegal), int'(m_state == 17));
            chk("count", int'(instr_count), m_count % 65536);
            chk("count4", int'(instr_count4), m_count % 16);
        end
    end

    task automatic wait_state(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clock);
            if (int'(state) == target) break;
        end
        if (i == budget) chk("timeout_state", int'(state), target);
    endtask

    task automatic wait_count(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clock);
            if (m_count == target) break;
        end
        if (i == budget) chk("timeout_count", m_count, target);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        int seq[9];
        int exp_seq[9];
        exp_seq = '{1, 2, 3, 16, 16, 5, 6, 7, 1};

        // reset state
        repeat (2) @(negedge clock);
        chk("rst_state", int'(state), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_flags", int'({paused, halted, illegal}), 0);
        chk("rst_count", int'(instr_count), 0);
        reset = 1'b0;
        mon_en = 1'b1;

        // LDAC walk
        ir_opcode = 4'd1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        seq[0] = int'(state);
        chk("ldac_run0", int'(running), 1);
        for (int i = 1; i < 9; i++) begin
            @(negedge clock);
            seq[i] = int'(state);
            chk("ldac_run", int'(running), 1);
        end
        for (int i = 0; i < 9; i++) chk("ldac_seq", seq[i], exp_seq[i]);
        chk("ldac_count", int'(instr_count), 1);

        // END while in FETCH1 of the next instruction
        ir_opcode = 4'd15;
        repeat (8) @(negedge clock);
        chk("end_state", int'(state), 15);
        chk("end_halted", int'(halted), 1);
        chk("end_count", int'(instr_count), 1);

        // restart from HALT into an illegal opcode
        ir_opcode = 4'd9;
        pulse_start();
        chk("restart_state", int'(state), 1);
        repeat (8) @(negedge clock);
        chk("err_state", int'(state), 17);
        chk("err_illegal", int'(illegal), 1);
        chk("err_running", int'(running), 0);
        repeat (20) @(negedge clock);
        chk("err_sticky", int'(state), 17);
        chk("err_count", int'(instr_count), 1);

        // single-step ADD
        step_en = 1'b1;
        ir_opcode = 4'd5;
        pulse_start();
        wait_state(13, 20);
        @(negedge clock);
        chk("step_state", int'(state), 0);
        chk("step_paused", int'(paused), 1);
        chk("step_count", int'(instr_count), 2);
        repeat (3) @(negedge clock);
        chk("step_hold", int'(state), 0);
        @(negedge clock);
        step_go = 1'b1;
        @(negedge clock);
        step_go = 1'b0;
        chk("stepgo_state", int'(state), 1);
        wait_state(13, 20);
        @(negedge clock);
        chk("step2_count", int'(instr_count), 3);
        // both resume inputs together, then both again while running
        start = 1'b1;
        step_go = 1'b1;
        @(negedge clock);
        start = 1'b0;
        step_go = 1'b0;
        chk("both_state", int'(state), 1);
        start = 1'b1;
        step_go = 1'b1;
        @(negedge clock);
        start = 1'b0;
        step_go = 1'b0;
        repeat (8) @(negedge clock);
        chk("once_state", int'(state), 0);
        chk("once_count", int'(instr_count), 4);

        // 16 CLACs: narrow counter wraps
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst2_count", int'(instr_count), 0);
        chk("rst2_paused", int'(paused), 0);
        step_en = 1'b0;
        ir_opcode = 4'd0;
        pulse_start();
        wait_count(15, 200);
        chk("wrap15", int'(instr_count4), 15);
        wait_count(16, 20);
        chk("wrap0", int'(instr_count4), 0);
        chk("wide16", int'(instr_count), 16);

        // reset in STAC2
        ir_opcode = 4'd2;
        wait_state(9, 40);
        reset = 1'b1;
        @(negedge clock);
        chk("stac_rst_state", int'(state), 0);
        chk("stac_rst_flags", int'({running, paused, halted, illegal}), 0);
        chk("stac_rst_count", int'(instr_count), 0);
        reset = 1'b0;

        // reset during DECODE
        ir_opcode = 4'd1;
        pulse_start();
        wait_state(16, 20);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("dec_rst_state", int'(state), 0);
        @(negedge clock);
        chk("dec_rst_idle", int'(state), 0);

        // clean LDAC after decode reset: decode still lasts two cycles
        pulse_start();
        wait_state(5, 20);
        chk("post_rst_ldac", int'(state), 5);
        repeat (4) @(negedge clock);
        chk("post_rst_count", int'(instr_count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
